// File: rtl/cache_arbiter_pkg.sv
// Shared types for the split-cache memory arbiter: LC-3b word/line types,
// arbiter state encoding and cacheline geometry.
package cache_arbiter_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;

  localparam int unsigned LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } lc3b_arb_state;

  // Clears the byte-offset bits so memory always sees a line-aligned address.
  function automatic lc3b_word line_align(input lc3b_word addr,
                                          input int unsigned offset_bits);
    lc3b_word mask;
    mask = '1;
    mask = mask << offset_bits;
    return addr & mask;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bundle of the instruction-cache, data-cache and physical-memory signals
// seen by the arbiter; slave is the arbiter's view, master the environment's.
interface cache_arbiter_if;
  import cache_arbiter_pkg::*;

  logic          i_pmem_read;
  lc3b_word      i_pmem_address;
  logic          i_pmem_resp;
  lc3b_cacheline i_pmem_rdata;

  logic          d_pmem_read;
  logic          d_pmem_write;
  lc3b_word      d_pmem_address;
  lc3b_cacheline d_pmem_wdata;
  logic          d_pmem_resp;
  lc3b_cacheline d_pmem_rdata;

  logic          pmem_resp;
  lc3b_cacheline pmem_rdata;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_cacheline pmem_wdata;

  modport slave (
    input  i_pmem_read, i_pmem_address,
    output i_pmem_resp, i_pmem_rdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output d_pmem_resp, d_pmem_rdata,
    input  pmem_resp, pmem_rdata,
    output pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output i_pmem_read, i_pmem_address,
    input  i_pmem_resp, i_pmem_rdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  d_pmem_resp, d_pmem_rdata,
    output pmem_resp, pmem_rdata,
    input  pmem_read, pmem_write, pmem_address, pmem_wdata
  );

endinterface

// File: rtl/cache_arbiter_control.sv
// Arbitration FSM: picks I or D in IDLE (round-robin on ties), tracks the
// transaction in flight and routes the completion pulse to its owner.
module cache_arbiter_control
  import cache_arbiter_pkg::*;
#(
  parameter logic RESET_LAST_GRANT_D = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic i_req,
  input  logic d_req,
  input  logic pmem_resp,
  output logic latch_en,
  output logic sel_d,
  output logic done,
  output logic i_resp,
  output logic d_resp
);

  lc3b_arb_state state_q, state_d;
  logic          last_grant_q, last_grant_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= RESET_LAST_GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    latch_en     = 1'b0;
    sel_d        = 1'b0;
    done         = 1'b0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state_q)
      IDLE: begin
        // last_grant_q == 1 means D won last, so a tie now goes to I.
        if (i_req && d_req) sel_d = ~last_grant_q;
        else                sel_d = d_req;
        if (i_req || d_req) begin
          latch_en     = 1'b1;
          last_grant_d = sel_d;
          state_d      = sel_d ? SERVE_D : SERVE_I;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          i_resp  = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          d_resp  = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-client cacheline arbiter in front of a single physical memory port:
// latches the granted request and holds registered strobes until pmem_resp.
module cache_arbiter
  import cache_arbiter_pkg::*;
#(
  parameter int unsigned OFFSET_BITS        = LINE_OFFSET_BITS,
  parameter logic        RESET_LAST_GRANT_D = 1'b0
) (
  input logic           clk,
  input logic           reset,
  cache_arbiter_if.slave bus
);

  logic          latch_en, sel_d, done, i_resp, d_resp;
  logic          i_req, d_req;

  lc3b_word      addr_q, addr_d;
  lc3b_cacheline wdata_q, wdata_d;
  logic          read_q, read_d;
  logic          write_q, write_d;

  assign i_req = bus.i_pmem_read;
  assign d_req = bus.d_pmem_read | bus.d_pmem_write;

  cache_arbiter_control #(
    .RESET_LAST_GRANT_D(RESET_LAST_GRANT_D)
  ) u_control (
    .clk      (clk),
    .reset    (reset),
    .i_req    (i_req),
    .d_req    (d_req),
    .pmem_resp(bus.pmem_resp),
    .latch_en (latch_en),
    .sel_d    (sel_d),
    .done     (done),
    .i_resp   (i_resp),
    .d_resp   (d_resp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  // Strobes are flops loaded at grant and cleared on completion, so they
  // never follow client inputs during a transaction.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    read_d  = read_q;
    write_d = write_q;
    if (latch_en) begin
      if (sel_d) begin
        addr_d  = line_align(bus.d_pmem_address, OFFSET_BITS);
        wdata_d = bus.d_pmem_wdata;
        write_d = bus.d_pmem_write;
        read_d  = ~bus.d_pmem_write;
      end else begin
        addr_d  = line_align(bus.i_pmem_address, OFFSET_BITS);
        wdata_d = '0;
        write_d = 1'b0;
        read_d  = 1'b1;
      end
    end else if (done) begin
      read_d  = 1'b0;
      write_d = 1'b0;
    end
  end

  assign bus.pmem_read    = read_q;
  assign bus.pmem_write   = write_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;

  assign bus.i_pmem_resp  = i_resp;
  assign bus.d_pmem_resp  = d_resp;
  assign bus.i_pmem_rdata = bus.pmem_rdata;
  assign bus.d_pmem_rdata = bus.pmem_rdata;

endmodule
